// File: rtl/prbs_gen_par_pkg.sv
// Shared definitions for the parallel PRBS generator: polynomial codes,
// per-code length/tap tables and the maximum register length.
package prbs_gen_par_pkg;

  localparam int MAX_LEN = 31;

  localparam logic [2:0] POLY_7  = 3'd0;
  localparam logic [2:0] POLY_15 = 3'd1;
  localparam logic [2:0] POLY_20 = 3'd2;
  localparam logic [2:0] POLY_23 = 3'd3;
  localparam logic [2:0] POLY_31 = 3'd4;

  // Reserved codes 5..7 map to the longest register so indexing stays in range.
  localparam logic [7:0][4:0] LEN_TABLE = {5'd31, 5'd31, 5'd31, 5'd31,
                                           5'd23, 5'd20, 5'd15, 5'd7};
  localparam logic [7:0][4:0] TAP_TABLE = {5'd28, 5'd28, 5'd28, 5'd28,
                                           5'd18, 5'd3,  5'd14, 5'd6};

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  function automatic logic polyLegal(input logic [2:0] code);
    return code <= POLY_31;
  endfunction

  function automatic logic [MAX_LEN-1:0] lenMask(input logic [4:0] len);
    return {MAX_LEN{1'b1}} >> (5'(MAX_LEN) - len);
  endfunction

endpackage

// File: rtl/prbs_gen_par_step.sv
// One Fibonacci LFSR bit step with run-time selectable length and tap.
module prbs_step
  import prbs_gen_par_pkg::*;
(
  input  logic [MAX_LEN-1:0] stateIn,
  input  logic [4:0]         len,
  input  logic [4:0]         tap,
  output logic [MAX_LEN-1:0] stateOut,
  output logic               bitOut
);

  logic [4:0] lenM1;
  logic [4:0] tapM1;
  logic       fb;

  assign lenM1  = len - 5'd1;
  assign tapM1  = tap - 5'd1;
  assign bitOut = stateIn[lenM1];
  assign fb     = stateIn[lenM1] ^ stateIn[tapM1];

  // Masking keeps every bit at or above the active length cleared.
  assign stateOut = {stateIn[MAX_LEN-2:0], fb} & lenMask(len);

endmodule

// File: rtl/prbs_gen_par.sv
// Parallel PRBS word generator with valid/ready output and transfer counter.
// Optional error injection on the word MSB is built with PRBS_ERR_INJ_EN.
module prbs_gen_par
  import prbs_gen_par_pkg::*;
#(
  parameter int W = 8
) (
  input  logic               Clk,
  input  logic               Reset,
`ifdef PRBS_ERR_INJ_EN
  input  logic               Inyectar,
`endif
  input  logic [MAX_LEN-1:0] Semilla,
  input  logic [2:0]         Longitud,
  input  logic               Cargar,
  input  logic               Habilitar,
  input  logic               Listo,
  output logic               Valido,
  output logic [W-1:0]       Salida,
  output logic [31:0]        Palabras
);

  state_e             stateQ, stateD;
  logic [2:0]         polyQ, polyD;
  logic [MAX_LEN-1:0] lfsrQ, lfsrD;
  logic [W-1:0]       salidaQ, salidaD;
  logic               validoQ, validoD;
  logic [31:0]        palabrasQ, palabrasD;

  logic [4:0]         curLen, curTap;
  logic [MAX_LEN-1:0] chain [0:W];
  logic [W-1:0]       wordBits;
  logic [MAX_LEN-1:0] seedMasked, loadVal;
  logic               transfer;

  assign curLen   = LEN_TABLE[polyQ];
  assign curTap   = TAP_TABLE[polyQ];
  assign chain[0] = lfsrQ;

  // W chained steps produce a whole word per cycle, oldest bit in the MSB.
  for (genvar i = 0; i < W; i++) begin : gStep
    prbs_step uStep (
      .stateIn (chain[i]),
      .len     (curLen),
      .tap     (curTap),
      .stateOut(chain[i+1]),
      .bitOut  (wordBits[W-1-i])
    );
  end

  assign seedMasked = Semilla & lenMask(LEN_TABLE[Longitud]);
  assign loadVal    = (seedMasked == '0) ? lenMask(LEN_TABLE[Longitud]) : seedMasked;
  assign transfer   = validoQ & Listo;

  always_comb begin
    stateD    = stateQ;
    polyD     = polyQ;
    lfsrD     = lfsrQ;
    salidaD   = salidaQ;
    validoD   = validoQ;
    palabrasD = palabrasQ;

    if (transfer) palabrasD = palabrasQ + 32'd1;

    if (Cargar) begin
      polyD   = Longitud;
      lfsrD   = loadVal;
      validoD = 1'b0;
      stateD  = ST_IDLE;
    end else begin
      case (stateQ)
        ST_IDLE: begin
          validoD = 1'b0;
          if (Habilitar && polyLegal(polyQ)) stateD = ST_RUN;
        end
        ST_RUN: begin
          // A word may only be replaced once the consumer has taken it.
          if (!validoQ || transfer) begin
            if (Habilitar) begin
              salidaD = wordBits;
              lfsrD   = chain[W];
              validoD = 1'b1;
            end else begin
              validoD = 1'b0;
              stateD  = ST_IDLE;
            end
          end
        end
        default: stateD = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateQ    <= ST_IDLE;
      polyQ     <= POLY_7;
      lfsrQ     <= '1;
      salidaQ   <= '0;
      validoQ   <= 1'b0;
      palabrasQ <= '0;
    end else begin
      stateQ    <= stateD;
      polyQ     <= polyD;
      lfsrQ     <= lfsrD;
      salidaQ   <= salidaD;
      validoQ   <= validoD;
      palabrasQ <= palabrasD;
    end
  end

`ifdef PRBS_ERR_INJ_EN
  logic         injQ, injD;
  logic [W-1:0] flipMask;

  assign injD = Inyectar | (injQ & ~transfer);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) injQ <= 1'b0;
    else        injQ <= injD;
  end

  // Only the presented word is corrupted; the LFSR sequence is untouched.
  always_comb begin
    flipMask      = '0;
    flipMask[W-1] = injQ & validoQ;
  end

  assign Salida = salidaQ ^ flipMask;
`else
  assign Salida = salidaQ;
`endif

  assign Valido   = validoQ;
  assign Palabras = palabrasQ;

endmodule

// File: tb/tb_prbs_gen_par.sv
// Scoreboard bench for prbs_gen_par: a bit-recurrence model fills the expected
// word queue; a negedge monitor compares every transferred word and counter.
module tb_prbs_gen_par;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [30:0]  Semilla;
  logic [2:0]   Longitud;
  logic         Cargar, Habilitar, Listo;
  logic         Valido;
  logic [W-1:0] Salida;
  logic [31:0]  Palabras;
`ifdef PRBS_ERR_INJ_EN
  logic         Inyectar;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] expQ[$];
  int expCount = 0;
  bit monEn = 0;
  bit armInj = 0;
  int injSeen = 0;
  int onesRx = 0;
  int bitsRx = 0;
  bit prevHold = 0;
  logic [W-1:0] prevSalida = '0;

  prbs_gen_par #(.W(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
`ifdef PRBS_ERR_INJ_EN
    .Inyectar (Inyectar),
`endif
    .Semilla  (Semilla),
    .Longitud (Longitud),
    .Cargar   (Cargar),
    .Habilitar(Habilitar),
    .Listo    (Listo),
    .Valido   (Valido),
    .Salida   (Salida),
    .Palabras (Palabras)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int polyL(input int code);
    case (code)
      0: return 7;
      1: return 15;
      2: return 20;
      3: return 23;
      default: return 31;
    endcase
  endfunction

  function automatic int polyT(input int code);
    case (code)
      0: return 6;
      1: return 14;
      2: return 3;
      3: return 18;
      default: return 28;
    endcase
  endfunction

  // Output stream: first L bits are the seed MSB-first, then x[n] = x[n-L] ^ x[n-T].
  task automatic pushWords(input int code, input logic [30:0] seed, input int n);
    int L, T;
    bit x[];
    longint unsigned s;
    logic [W-1:0] wd;
    L = polyL(code);
    T = polyT(code);
    s = longint'(seed) & ((64'd1 << L) - 1);
    if (s == 0) s = (64'd1 << L) - 1;
    x = new[n * W];
    for (int i = 0; i < n * W; i++) begin
      if (i < L) x[i] = s[L-1-i];
      else       x[i] = x[i-L] ^ x[i-T];
    end
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < W; b++) wd[W-1-b] = x[k*W + b];
      expQ.push_back(wd);
    end
  endtask

  always @(negedge Clk) begin
    logic [W-1:0] exp;
    if (Reset && monEn) begin
      if (prevHold) begin
        checkOutput("holdValido", 32'(Valido), 32'd1);
        checkOutput("holdSalida", 32'(Salida), 32'(prevSalida));
      end
      checkOutput("palabras", Palabras, expCount);
      if (Valido && Listo) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedWord", 32'(Salida), 32'hDEAD_BEEF);
        end else begin
          exp = expQ.pop_front();
          if (armInj) begin
            exp[W-1] = ~exp[W-1];
            armInj = 0;
            injSeen++;
          end
          checkOutput("word", 32'(Salida), 32'(exp));
        end
        for (int b = W - 1; b >= 0; b--) begin
          if (bitsRx < 32767) begin
            bitsRx++;
            onesRx += int'(Salida[b]);
          end
        end
        expCount++;
      end
      prevHold   = Valido && !Listo;
      prevSalida = Salida;
    end else begin
      prevHold = 0;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic loadSeed(input int code, input logic [30:0] seed, input int nWords);
    Longitud = 3'(code);
    Semilla  = seed;
    Cargar   = 1'b1;
    Listo    = 1'b1;
    step();
    Cargar = 1'b0;
    expQ.delete();
    bitsRx = 0;
    onesRx = 0;
    if (code <= 4) pushWords(code, seed, nWords);
  endtask

  task automatic runWords(input int n, input int listoPct);
    int target;
    target = expCount + n;
    for (int c = 0; c < n * 20 + 50; c++) begin
      Listo = ($urandom_range(0, 99) < listoPct);
      step();
      if (expCount >= target) break;
    end
    checkOutput("runTimeout", expCount >= target, 1);
  endtask

  task automatic applyStimulus();
    int saved;
    Reset = 1'b0; Semilla = '0; Longitud = '0; Cargar = 0; Habilitar = 0; Listo = 0;
`ifdef PRBS_ERR_INJ_EN
    Inyectar = 1'b0;
`endif
    #2;
    checkOutput("rstValido", 32'(Valido), 0);
    checkOutput("rstSalida", 32'(Salida), 0);
    checkOutput("rstPalabras", Palabras, 0);
    step();
    Reset = 1'b1;
    monEn = 1;

    // Run mode 0 to exactly 57 transfers, then reset mid-cycle.
    Habilitar = 1'b1;
    loadSeed(0, 31'h7F, 80);
    step();
    checkOutput("latencyIdle", 32'(Valido), 0);
    step();
    checkOutput("firstValid", 32'(Valido), 1);
    checkOutput("firstWord", 32'(Salida), 32'hFE);
    runWords(57 - expCount, 100);
    checkOutput("palabras57", Palabras, 57);
    #2;
    monEn = 0;
    Reset = 1'b0;
    #1;
    checkOutput("midRstValido", 32'(Valido), 0);
    checkOutput("midRstSalida", 32'(Salida), 0);
    checkOutput("midRstPalabras", Palabras, 0);
    step();
    Reset = 1'b1;
    expQ.delete();
    expCount = 0;
    pushWords(0, 31'h7FFF_FFFF, 40);
    monEn = 1;
    step();
    checkOutput("postRstIdle", 32'(Valido), 0);
    step();
    checkOutput("postRstValid", 32'(Valido), 1);
    runWords(36, 100);

    // Period-127 stream from an all-ones seed, then stall handling.
    loadSeed(0, 31'h7F, 200);
    runWords(40, 100);
    runWords(40, 50);
    Listo = 1'b0;
    repeat (5) step();
    runWords(10, 100);

    // Remaining polynomials with random seeds plus a zero seed.
    for (int code = 1; code <= 4; code++) begin
      loadSeed(code, 31'($urandom()), 120);
      runWords(40, 70);
    end
    loadSeed(2, 31'h0, 120);
    runWords(30, 70);

    // Enable drop stops without losing bits; re-enable resumes the stream.
    loadSeed(3, 31'($urandom()), 120);
    runWords(10, 100);
    Listo = 1'b1;
    Habilitar = 1'b0;
    step();
    step();
    checkOutput("disableValido", 32'(Valido), 0);
    Habilitar = 1'b1;
    runWords(10, 80);

`ifdef PRBS_ERR_INJ_EN
    loadSeed(4, 31'($urandom()), 120);
    runWords(5, 100);
    Listo = 1'b0;
    Inyectar = 1'b1;
    step();
    Inyectar = 1'b0;
    armInj = 1;
    runWords(10, 100);
    checkOutput("injOnce", injSeen, 1);
`endif

    // Full 2^15-1 bit period of mode 1 from a zero seed.
    loadSeed(1, 31'h0, 4200);
    runWords(4100, 100);
    checkOutput("m15Bits", bitsRx, 32767);
    checkOutput("m15Ones", onesRx, 16384);

    // Reserved polynomial keeps the generator idle.
    loadSeed(5, 31'($urandom()), 0);
    saved = expCount;
    for (int c = 0; c < 100; c++) begin
      step();
      checkOutput("rsvValido", 32'(Valido), 0);
      checkOutput("rsvPalabras", Palabras, saved);
    end
  endtask

  initial begin
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
